toggle_event_decoder: RTL and testbench

// Receive end of the toggle-event link driven by t_flipflop-based encoders: every level change on
// tog_in means one event. Synchronises tog_in into clk, turns each change into a one-cycle pulse,

---
 rtl/toggle_event_decoder.sv | 117 +++++++++++
 tb/tb_toggle_event_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: receive side of a toggle-encoded event link.
// Synchronises tog_in, turns each level change into a one-cycle evt_pulse,
// keeps a wrapping event count and a saturating pending-event counter that is
// drained through a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// WARM  | after reset; last-sample tracks sync output, no events raised
// RUN   | normal detection: every sync_out change yields one evt_pulse
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int PEND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tog_in,
  input  logic                  clr,
  input  logic                  evt_ready,
  output logic                  evt_valid,
  output logic                  evt_pulse,
  output logic [CNT_WIDTH-1:0]  evt_count,
  output logic [PEND_WIDTH-1:0] pend_count,
  output logic                  overflow
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0]     WARM_LOAD = WARM_W'(SYNC_STAGES);
  localparam logic [PEND_WIDTH-1:0] PEND_CAP  = '1;

  typedef enum logic {WARM, RUN} state_t;

  state_t                 state_q, state_d;
  logic [WARM_W-1:0]      warm_cnt_q, warm_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   last_q;
  logic                   toggle;
  logic                   accept;
  logic                   ovf_set;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign evt_valid = (pend_count != '0);
  assign accept    = evt_valid & evt_ready;
  // A pulse that meets a full buffer with no simultaneous accept is lost.
  assign ovf_set   = evt_pulse & ~accept & (pend_count == PEND_CAP);

  // Synchroniser chain and last-sample register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      last_q <= sync_out;
    end
  end

  // Warm-up FSM state and down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WARM;
      warm_cnt_q <= WARM_LOAD;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Next-state logic: WARM spans SYNC_STAGES+1 edges, then toggles are live.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    toggle     = 1'b0;
    case (state_q)
      WARM: begin
        if (warm_cnt_q == '0) state_d = RUN;
        else                  warm_cnt_d = warm_cnt_q - 1'b1;
      end
      RUN: toggle = sync_out ^ last_q;
      default: state_d = WARM;
    endcase
  end

  // Registered event strobe and wrapping event counter (clr wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_pulse <= 1'b0;
      evt_count <= '0;
    end else begin
      evt_pulse <= toggle;
      if (clr)            evt_count <= '0;
      else if (evt_pulse) evt_count <= evt_count + 1'b1;
    end
  end

  // Pending-event counter; simultaneous inc and accept cancel even when full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_count <= '0;
    end else begin
      case ({evt_pulse, accept})
        2'b10:   if (pend_count != PEND_CAP) pend_count <= pend_count + 1'b1;
        2'b01:   pend_count <= pend_count - 1'b1;
        default: pend_count <= pend_count;
      endcase
    end
  end

  // Sticky overflow flag; a new loss in the same cycle as clr keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (clr)     overflow <= 1'b0;
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Testbench for toggle_event_decoder: table-driven cycle vectors for the basic
// pulse/count/handshake behaviour, plus hand-written multi-cycle sequences for
// overflow, simultaneous inc/accept, wrap, clr priority and async reset.
module tb_toggle_event_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tog_in = 1'b0;
  logic       clr = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic       evt_pulse;
  logic [7:0] evt_count;
  logic [3:0] pend_count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int n_acc;

  typedef struct packed {
    logic       tog;
    logic       clr;
    logic       rdy;
    logic       pulse;
    logic [7:0] cnt;
    logic [3:0] pend;
    logic       valid;
    logic       ovf;
  } vec_t;

  vec_t tbl [11];

  toggle_event_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .tog_in     (tog_in),
    .clr        (clr),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_pulse  (evt_pulse),
    .evt_count  (evt_count),
    .pend_count (pend_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pulse"}, 32'(evt_pulse), 0);
    chk({tag, "_count"}, 32'(evt_count), 0);
    chk({tag, "_pend"},  32'(pend_count), 0);
    chk({tag, "_valid"}, 32'(evt_valid), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    evt_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
  endtask

  task automatic toggle5();
    tog_in = ~tog_in;
    repeat (5) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: tog_in high through reset and release gives no event
    tog_in = 1'b1;
    #1 rst = 1'b1;
    repeat (3) step();
    chk_all_zero("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t1_no_pulse", 32'(evt_pulse), 0);
    end
    chk("t1_count", 32'(evt_count), 0);
    chk("t1_valid", 32'(evt_valid), 0);

    // Test 2: per-cycle vectors from a clean reset with tog_in low
    tog_in = 1'b0;
    do_reset();
    //            tog   clr   rdy   pulse cnt    pend   valid ovf
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 4'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd1, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tog_in    = tbl[i].tog;
      clr       = tbl[i].clr;
      evt_ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_pulse", i), 32'(evt_pulse),  32'(tbl[i].pulse));
      chk($sformatf("v%0d_count", i), 32'(evt_count),  32'(tbl[i].cnt));
      chk($sformatf("v%0d_pend", i),  32'(pend_count), 32'(tbl[i].pend));
      chk($sformatf("v%0d_valid", i), 32'(evt_valid),  32'(tbl[i].valid));
      chk($sformatf("v%0d_ovf", i),   32'(overflow),   32'(tbl[i].ovf));
    end
    clr = 1'b0;
    evt_ready = 1'b0;

    // Test 3: 17 toggles with no consumer saturate at 15 and set overflow
    do_reset();
    repeat (15) toggle5();
    chk("t3_pend15", 32'(pend_count), 15);
    chk("t3_ovf_not_yet", 32'(overflow), 0);
    toggle5();
    chk("t3_ovf_set", 32'(overflow), 1);
    toggle5();
    chk("t3_pend_sat", 32'(pend_count), 15);
    chk("t3_count17", 32'(evt_count), 17);
    chk("t3_ovf_sticky", 32'(overflow), 1);
    evt_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!evt_valid) break;
      step();
      n_acc++;
    end
    evt_ready = 1'b0;
    chk("t3_accepts", 32'(n_acc), 15);
    chk("t3_valid_low", 32'(evt_valid), 0);

    // Test 4: full buffer, pulse and accept on the same edge
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_ovf", 32'(overflow), 0);
    chk("t4_clr_count", 32'(evt_count), 0);
    repeat (15) toggle5();
    chk("t4_pend15", 32'(pend_count), 15);
    tog_in = ~tog_in;
    repeat (3) step();
    chk("t4_pulse", 32'(evt_pulse), 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("t4_pend_hold", 32'(pend_count), 15);
    chk("t4_no_ovf", 32'(overflow), 0);
    repeat (3) step();
    chk("t4_pend_after", 32'(pend_count), 15);

    // Test 5: 256 toggles with consumer ready wrap the count to 0
    do_reset();
    evt_ready = 1'b1;
    repeat (255) toggle5();
    chk("t5_count255", 32'(evt_count), 255);
    toggle5();
    chk("t5_wrap", 32'(evt_count), 0);
    chk("t5_pend0", 32'(pend_count), 0);
    chk("t5_ovf0", 32'(overflow), 0);
    toggle5();
    chk("t5_count1", 32'(evt_count), 1);
    tog_in = ~tog_in;
    repeat (3) step();
    chk("t5_pulse", 32'(evt_pulse), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr_wins", 32'(evt_count), 0);
    evt_ready = 1'b0;

    // Test 6: async reset with 4 pending and a toggle in the synchroniser
    do_reset();
    repeat (4) toggle5();
    chk("t6_pend4", 32'(pend_count), 4);
    chk("t6_count4", 32'(evt_count), 4);
    tog_in = ~tog_in;
    step();
    #2 rst = 1'b1;
    #1;
    chk_all_zero("t6_async");
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_no_pulse", 32'(evt_pulse), 0);
    end
    chk("t6_count0", 32'(evt_count), 0);
    chk("t6_pend0", 32'(pend_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
